// File: rtl/bait_pkg.sv
// Shared state codes and default depth/step constants for the bait controller.
package bait_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FISHING = 3'd1,
        ST_HOOKED  = 3'd2,
        ST_REEL    = 3'd3,
        ST_LANDED  = 3'd4
    } bait_state_e;

    localparam int unsigned DEF_SURFACE     = 720;
    localparam int unsigned DEF_BOTTOM      = 4650;
    localparam int unsigned DEF_SINK_STEP   = 40;
    localparam int unsigned DEF_RISE_STEP   = 40;
    localparam int unsigned DEF_REEL_STEP   = 60;
    localparam int unsigned DEF_LAND_FRAMES = 30;

    function automatic logic [13:0] clamp_depth(input logic [13:0] v,
                                                input logic [13:0] lo,
                                                input logic [13:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/bait_stepper.sv
// Saturating move of a depth toward a target by at most one step; never overshoots.
module bait_stepper (
    input  logic [13:0] current,
    input  logic [13:0] target,
    input  logic [14:0] step,
    output logic [13:0] next
);

    logic [14:0] cur_w;
    logic [14:0] tgt_w;
    logic [14:0] diff;
    logic [14:0] mv;
    logic [14:0] res;

    always_comb begin
        cur_w = {1'b0, current};
        tgt_w = {1'b0, target};
        if (tgt_w >= cur_w) begin
            diff = tgt_w - cur_w;
            mv   = (diff < step) ? diff : step;
            res  = cur_w + mv;
        end else begin
            diff = cur_w - tgt_w;
            mv   = (diff < step) ? diff : step;
            res  = cur_w - mv;
        end
        next = 14'(res);
    end

endmodule

// File: rtl/bait_ctrl.sv
// Fishing-line controller: cast, follow the mouse, hook, reel in and report catches.
module bait_ctrl
    import bait_pkg::*;
#(
    parameter int unsigned SURFACE     = DEF_SURFACE,
    parameter int unsigned BOTTOM      = DEF_BOTTOM,
    parameter int unsigned SINK_STEP   = DEF_SINK_STEP,
    parameter int unsigned RISE_STEP   = DEF_RISE_STEP,
    parameter int unsigned REEL_STEP   = DEF_REEL_STEP,
    parameter int unsigned LAND_FRAMES = DEF_LAND_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [13:0] mouse_v,
    input  logic        btn_cast,
    input  logic        fish_hit,
    input  logic [2:0]  fish_id,
    output logic [13:0] bait_v,
    output logic [2:0]  state,
    output logic        hooked,
    output logic        catch_pulse,
    output logic [2:0]  catch_id
);

    localparam logic [13:0] SURF_D    = 14'(SURFACE);
    localparam logic [13:0] BOT_D     = 14'(BOTTOM);
    localparam logic [14:0] SINK_S    = 15'(SINK_STEP);
    localparam logic [14:0] RISE_S    = 15'(RISE_STEP);
    localparam logic [14:0] REEL_S    = 15'(REEL_STEP);
    localparam logic [15:0] LAND_LAST = 16'(LAND_FRAMES - 1);

    bait_state_e state_q, state_d;
    logic [13:0] bait_q, bait_d;
    logic [15:0] land_cnt_q, land_cnt_d;
    logic [2:0]  catch_id_q, catch_id_d;
    logic        hooked_q, hooked_d;
    logic        catch_pulse_q, catch_pulse_d;

    logic [13:0] step_target;
    logic [14:0] step_size;
    logic [13:0] step_next;

    bait_stepper u_stepper (
        .current (bait_q),
        .target  (step_target),
        .step    (step_size),
        .next    (step_next)
    );

    always_comb begin
        state_d       = state_q;
        bait_d        = bait_q;
        land_cnt_d    = land_cnt_q;
        catch_id_d    = catch_id_q;
        catch_pulse_d = 1'b0;
        step_target   = SURF_D;
        step_size     = REEL_S;

        case (state_q)
            ST_IDLE: begin
                bait_d = SURF_D;
                if (btn_cast)
                    state_d = ST_FISHING;
            end
            ST_FISHING: begin
                step_target = clamp_depth(mouse_v, SURF_D, BOT_D);
                step_size   = (step_target > bait_q) ? SINK_S : RISE_S;
                // A transition cycle freezes the depth even when a frame tick coincides.
                if (fish_hit) begin
                    state_d    = ST_HOOKED;
                    catch_id_d = fish_id;
                end else if (btn_cast) begin
                    state_d = ST_REEL;
                end else if (frame_tick) begin
                    bait_d = step_next;
                end
            end
            ST_HOOKED, ST_REEL: begin
                if (frame_tick) begin
                    if (bait_q == SURF_D)
                        state_d = (state_q == ST_HOOKED) ? ST_LANDED : ST_IDLE;
                    else
                        bait_d = step_next;
                end
            end
            ST_LANDED: begin
                if (frame_tick) begin
                    if (land_cnt_q == LAND_LAST) begin
                        catch_pulse_d = 1'b1;
                        land_cnt_d    = '0;
                        state_d       = ST_IDLE;
                    end else begin
                        land_cnt_d = land_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        hooked_d = (state_d == ST_HOOKED) || (state_d == ST_LANDED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bait_q        <= SURF_D;
            land_cnt_q    <= '0;
            catch_id_q    <= '0;
            hooked_q      <= 1'b0;
            catch_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bait_q        <= bait_d;
            land_cnt_q    <= land_cnt_d;
            catch_id_q    <= catch_id_d;
            hooked_q      <= hooked_d;
            catch_pulse_q <= catch_pulse_d;
        end
    end

    assign bait_v      = bait_q;
    assign state       = state_q;
    assign hooked      = hooked_q;
    assign catch_pulse = catch_pulse_q;
    assign catch_id    = catch_id_q;

endmodule

// File: tb/tb_bait_ctrl.sv
// Scoreboard bench for bait_ctrl: a behavioural model queues expected outputs, a monitor compares.
module tb_bait_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic [13:0] mouse_v = '0;
    logic        btn_cast = 1'b0;
    logic        fish_hit = 1'b0;
    logic [2:0]  fish_id = '0;
    logic [13:0] bait_v;
    logic [2:0]  state;
    logic        hooked;
    logic        catch_pulse;
    logic [2:0]  catch_id;

    bait_ctrl #(
        .SURFACE     (720),
        .BOTTOM      (4650),
        .SINK_STEP   (40),
        .RISE_STEP   (40),
        .REEL_STEP   (60),
        .LAND_FRAMES (30)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .mouse_v     (mouse_v),
        .btn_cast    (btn_cast),
        .fish_hit    (fish_hit),
        .fish_id     (fish_id),
        .bait_v      (bait_v),
        .state       (state),
        .hooked      (hooked),
        .catch_pulse (catch_pulse),
        .catch_id    (catch_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int bait;
        int hk;
        int pulse;
        int id;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   pulses_seen = 0;

    // Reference model: plain game rules, one sampled clock edge at a time.
    int m_st = 0, m_bait = 720, m_cnt = 0, m_id = 0, m_pulse = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_edge(input bit r, input bit t, input int mv, input bit c,
                              input bit h, input int f);
        int tgt;
        if (r) begin
            m_st = 0; m_bait = 720; m_cnt = 0; m_id = 0; m_pulse = 0;
            return;
        end
        m_pulse = 0;
        if (m_st == 0) begin
            m_bait = 720;
            if (c) m_st = 1;
        end else if (m_st == 1) begin
            if (h) begin
                m_st = 2; m_id = f;
            end else if (c) begin
                m_st = 3;
            end else if (t) begin
                tgt = (mv < 720) ? 720 : ((mv > 4650) ? 4650 : mv);
                if (tgt > m_bait) m_bait += imin(40, tgt - m_bait);
                else              m_bait -= imin(40, m_bait - tgt);
            end
        end else if (m_st == 2 || m_st == 3) begin
            if (t) begin
                if (m_bait == 720) m_st = (m_st == 2) ? 4 : 0;
                else               m_bait -= imin(60, m_bait - 720);
            end
        end else if (m_st == 4) begin
            if (t) begin
                m_cnt++;
                if (m_cnt == 30) begin
                    m_pulse = 1; m_st = 0; m_cnt = 0;
                end
            end
        end else begin
            m_st = 0;
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue what the next rising edge must produce.
    task automatic cyc(input bit r, input bit t, input int mv, input bit c,
                       input bit h, input int f);
        exp_t e;
        @(negedge clk);
        rst = r; frame_tick = t; mouse_v = 14'(mv); btn_cast = c; fish_hit = h; fish_id = 3'(f);
        model_edge(r, t, mv, c, h, f);
        e.st = m_st; e.bait = m_bait; e.hk = (m_st == 2 || m_st == 4) ? 1 : 0;
        e.pulse = m_pulse; e.id = m_id;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (catch_pulse) pulses_seen++;
                if (int'(state) != e.st || int'(bait_v) != e.bait || int'(hooked) != e.hk ||
                    int'(catch_pulse) != e.pulse || int'(catch_id) != e.id) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got st=%0d bait=%0d hk=%0d pulse=%0d id=%0d, exp st=%0d bait=%0d hk=%0d pulse=%0d id=%0d",
                             $time, state, bait_v, hooked, catch_pulse, catch_id,
                             e.st, e.bait, e.hk, e.pulse, e.id);
                end
            end
        end
    end

    task automatic bound_fail(input string name);
        miscompares++;
        $display("FAIL %s: model never reached required condition within budget", name);
    endtask

    task automatic run_to_idle(input string name);
        int n = 0;
        while (m_st != 0 && n < 400) begin
            cyc(0, 1, 0, 0, 0, 0);
            n++;
        end
        if (m_st != 0) bound_fail(name);
    endtask

    initial begin : stim
        int n;
        int expect_pulses;
        repeat (3) cyc(1, 1, 2000, 1, 1, 7);

        // cast and follow to 1000, then hold
        cyc(0, 0, 1000, 1, 0, 0);
        repeat (12) cyc(0, 1, 1000, 0, 0, 0);
        repeat (5) cyc(0, 0, 3000, 0, 0, 0);

        // clamp at bottom, then back up to surface
        repeat (110) cyc(0, 1, 9000, 0, 0, 0);
        repeat (110) cyc(0, 1, 0, 0, 0, 0);

        // catch at 1080 with fish 5; hit lands on a tick cycle (no move)
        n = 0;
        while (m_bait != 1080 && n < 200) begin
            cyc(0, ($urandom_range(0, 2) != 0), 1080, 0, 0, 0);
            n++;
        end
        if (m_bait != 1080) bound_fail("reach_1080");
        cyc(0, 1, 1080, 0, 1, 5);
        n = 0;
        while (m_st != 0 && n < 400) begin
            cyc(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 16383),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), $urandom_range(0, 7));
            n++;
        end
        if (m_st != 0) bound_fail("catch_to_idle");

        // hit and cast together: hit wins
        cyc(0, 0, 2000, 1, 0, 0);
        repeat (20) cyc(0, 1, 2000, 0, 0, 0);
        cyc(0, 1, 2000, 1, 1, $urandom_range(0, 7));
        run_to_idle("priority_to_idle");

        // empty reel
        cyc(0, 0, 3000, 1, 0, 0);
        repeat (25) cyc(0, 1, 3000, 0, 0, 0);
        cyc(0, 1, 3000, 1, 0, 2);
        run_to_idle("reel_to_idle");
        repeat (3) cyc(0, 1, 3000, 0, 0, 0);

        // reset in the middle of LANDED
        cyc(0, 0, 1500, 1, 0, 0);
        repeat (10) cyc(0, 1, 1500, 0, 0, 0);
        cyc(0, 0, 1500, 0, 1, 6);
        n = 0;
        while (!(m_st == 4 && m_cnt == 15) && n < 400) begin
            cyc(0, 1, 1500, 0, 0, 0);
            n++;
        end
        if (!(m_st == 4 && m_cnt == 15)) bound_fail("landed_15");
        cyc(1, 1, 1500, 0, 0, 0);
        repeat (40) cyc(0, 1, 1500, 0, 0, 0);

        // random play
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0),
                $urandom_range(0, 16383), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 29) == 0), $urandom_range(0, 7));
        end
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #3;

        // at least the directed catch must have produced a pulse
        expect_pulses = 1;
        vectors++;
        if (pulses_seen < expect_pulses) begin
            miscompares++;
            $display("FAIL catch_count: got %0d pulses, need at least %0d", pulses_seen, expect_pulses);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
